// File: rtl/fma_tv_sequencer.sv
// fma_tv_sequencer: streams packed FMA test vectors from memory,
// drives the unit under test and checks results at a fixed latency.
module fma_tv_sequencer #(
  parameter int FLEN    = 16,
  parameter int FLAGS_W = 4,
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        check_flags,
  input  logic                        stop_on_error,
  output logic                        vec_rd_en,
  output logic [ADDR_W-1:0]           vec_addr,
  input  logic [4*FLEN+FLAGS_W+8:0]   vec_data,
  output logic [FLEN-1:0]             x,
  output logic [FLEN-1:0]             y,
  output logic [FLEN-1:0]             z,
  output logic                        mul,
  output logic                        add,
  output logic                        negp,
  output logic                        negz,
  output logic [1:0]                  roundmode,
  output logic                        op_valid,
  input  logic [FLEN-1:0]             result,
  input  logic [FLAGS_W-1:0]          flags,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_W-1:0]            vector_count,
  output logic [CNT_W-1:0]            error_count,
  output logic [CNT_W-1:0]            first_err_index,
  output logic [FLEN-1:0]             first_err_result,
  output logic [FLAGS_W-1:0]          first_err_flags
);

  localparam int RO = FLAGS_W;
  localparam int CO = RO + FLEN;
  localparam int ZO = CO + 8;
  localparam int YO = ZO + FLEN;
  localparam int XO = YO + FLEN;
  localparam int VW = XO + FLEN + 1;

  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [CNT_W-1:0]  CONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] AMAX = '1;
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              rd_act_q;
  logic              rd_pend_q;
  logic              chk_flg_q;
  logic              stop_err_q;
  logic              err_seen_q;
  logic [ADDR_W-1:0] addr_q;

  logic [FLEN-1:0]   x_q, y_q, z_q;
  logic [5:0]        ctrl_q;

  logic [LATENCY:0]  pv_q;
  logic [FLEN-1:0]   pr_q [LATENCY+1];
  logic [FLAGS_W-1:0] pf_q [LATENCY+1];

  logic [CNT_W-1:0]  vcnt_q, ecnt_q, eidx_q;
  logic [FLEN-1:0]   eres_q;
  logic [FLAGS_W-1:0] eflg_q;

  logic go, chk, mis, halt, sent, issue, in_vld;
  logic unused_ctrl;

  assign in_vld      = vec_data[VW-1];
  assign unused_ctrl = ^vec_data[CO+6 +: 2];

  assign go    = start && (state_q == IDLE || state_q == DONE);
  assign chk   = pv_q[LATENCY];
  assign mis   = chk && ((result != pr_q[LATENCY]) ||
                 (chk_flg_q && (flags != pf_q[LATENCY])));
  // First recorded error also squashes the word returning this edge.
  assign halt  = mis && stop_err_q && !err_seen_q;
  assign sent  = state_q == RUN && rd_pend_q && !in_vld;
  assign issue = state_q == RUN && rd_pend_q && in_vld && !halt;

  assign vec_rd_en = state_q == RUN && rd_act_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (halt || sent || (!rd_act_q && !rd_pend_q))
               state_d = DRAIN;
      DRAIN: if (~|pv_q) state_d = DONE;
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_act_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      chk_flg_q  <= 1'b0;
      stop_err_q <= 1'b0;
      err_seen_q <= 1'b0;
      addr_q     <= '0;
      vcnt_q     <= '0;
      ecnt_q     <= '0;
      eidx_q     <= '0;
      eres_q     <= '0;
      eflg_q     <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        rd_act_q   <= 1'b1;
        rd_pend_q  <= 1'b0;
        chk_flg_q  <= check_flags;
        stop_err_q <= stop_on_error;
        err_seen_q <= 1'b0;
        addr_q     <= '0;
        vcnt_q     <= '0;
        ecnt_q     <= '0;
        eidx_q     <= '0;
        eres_q     <= '0;
        eflg_q     <= '0;
      end else begin
        rd_pend_q <= vec_rd_en;
        if (vec_rd_en) begin
          addr_q <= addr_q + AONE;
          if (addr_q == AMAX) rd_act_q <= 1'b0;
        end
        if (chk) begin
          if (vcnt_q != CMAX) vcnt_q <= vcnt_q + CONE;
          if (mis) begin
            if (ecnt_q != CMAX) ecnt_q <= ecnt_q + CONE;
            if (!err_seen_q) begin
              err_seen_q <= 1'b1;
              eidx_q     <= vcnt_q;
              eres_q     <= result;
              eflg_q     <= flags;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      ctrl_q <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        pr_q[i] <= '0;
        pf_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issue;
      if (issue) begin
        x_q     <= vec_data[XO +: FLEN];
        y_q     <= vec_data[YO +: FLEN];
        z_q     <= vec_data[ZO +: FLEN];
        ctrl_q  <= vec_data[CO +: 6];
        pr_q[0] <= vec_data[RO +: FLEN];
        pf_q[0] <= vec_data[0 +: FLAGS_W];
      end
      for (int i = 1; i <= LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pr_q[i] <= pr_q[i-1];
        pf_q[i] <= pf_q[i-1];
      end
    end
  end

  assign vec_addr  = addr_q;
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign negz      = ctrl_q[0];
  assign negp      = ctrl_q[1];
  assign add       = ctrl_q[2];
  assign mul       = ctrl_q[3];
  assign roundmode = ctrl_q[5:4];
  assign op_valid  = pv_q[0];

  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass = state_q == DONE && ecnt_q == '0;

  assign vector_count     = vcnt_q;
  assign error_count      = ecnt_q;
  assign first_err_index  = eidx_q;
  assign first_err_result = eres_q;
  assign first_err_flags  = eflg_q;

endmodule

// File: doc/fma_tv_sequencer.md
# fma_tv_sequencer

Synthesizable, parametrised test-vector sequencer and checker for the FMA datapath (fma16 and wider successors). Streams packed vectors from a synchronous-read vector memory, drives operands and control to the unit under test, aligns expected result and flags through a configurable latency pipeline, and counts vectors and mismatches. It replaces simulation-only vector checking so FMA units can be self-checked in emulation and on FPGA, and adds flag checking and pipelined-DUT support.

## Interface
- FLEN, 16: operand/result width (16, 32, 64).
- FLAGS_W, 4: exception flag width.
- ADDR_W, 14: vector memory address width; max vectors 2^ADDR_W.
- LATENCY, 0: DUT result latency in cycles after operands are presented (0 = combinational DUT).
- CNT_W, 32: vector and error counter width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from address 0 (ignored unless IDLE or DONE).
- check_flags  in  1  1 = flag mismatch counts as error; sampled at start.
- stop_on_error  in  1  1 = halt issuing after first error; sampled at start.
- vec_rd_en  out  1  memory read enable.
- vec_addr  out  ADDR_W  memory read address.
- vec_data  in  1+4*FLEN+8+FLAGS_W  {valid, x, y, z, ctrl[7:0], rexpected, flagsexpected}; returned one cycle after vec_rd_en.
- x, y, z  out  FLEN each  operands.
- mul, add, negp, negz  out  1 each  ctrl[3:0] fields (negz = ctrl[0]).
- roundmode  out  2  ctrl[5:4].
- op_valid  out  1  operands valid this cycle.
- result  in  FLEN  DUT result.
- flags  in  FLAGS_W  DUT flags.
- busy, done, pass  out  1 each  status; pass valid only when done.
- vector_count, error_count  out  CNT_W each  checked vectors / mismatches (saturating).
- first_err_index  out  CNT_W  index of first mismatching vector.
- first_err_result  out  FLEN  DUT result of first mismatch.
- first_err_flags  out  FLAGS_W  DUT flags of first mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0. start -> RUN; clears counters, first_err_*, latches check_flags/stop_on_error.
- RUN: vec_rd_en=1 every cycle, vec_addr increments by 1 from 0. Returned word with valid=1 loads x/y/z/ctrl registers and asserts op_valid next cycle; rexpected/flagsexpected enter an expected pipeline of depth LATENCY+1 alongside op_valid.
- End of stream: returned word with valid=0 (sentinel), or vec_addr wrap past 2^ADDR_W-1 -> stop reads (vec_rd_en=0), go DRAIN. Sentinel word is never issued.
- stop_on_error=1 and first error recorded -> stop reads immediately, discard data already in flight from memory, go DRAIN.
- DRAIN: wait until expected pipeline empty (no valid stage), then DONE.
- DONE: done=1, busy=0, pass=(error_count==0); counters held. start -> RUN (new run); otherwise stay.
- Check: at each edge where aligned op_valid is set, vector_count+=1; error if result!=rexpected, or check_flags && flags!=flagsexpected. Error: error_count+=1; if first error, capture index (vector_count before increment), result, flags.
- Counters saturate at 2^CNT_W-1.
- Comparison is bitwise exact (NaN payload included).

## Timing
- Reset (any state, including mid-run): state IDLE, all outputs 0, pipeline valids cleared; in-flight memory data discarded.
- Start sampled at edge E0. Cycle after E0: vec_rd_en=1, vec_addr=0. E1: memory read. E2: operand registers load, op_valid=1 during cycle after E2.
- Vector issued on edge Ek (op_valid high in the cycle following Ek) is checked on edge Ek+LATENCY+1.
- Throughput: one vector per cycle, no bubbles while valid=1.
- Sentinel at address N returns at E(N+1)+... i.e. one cycle after its read; reads of N+1 already issued are discarded.
- DONE reached LATENCY+1 edges after last issue (plus one for state update); done asserted for all cycles in DONE.
- busy=1 in RUN and DRAIN only.

## Test plan
- LATENCY=0, vectors {3C00,4000,0000,ctrl mul+add,rne, exp 4000, flags 0} then sentinel -> vector_count=1, error_count=0, pass=1, op_valid exactly one cycle.
- 100 correct vectors + one with rexpected=4001 at index 57, FLEN=16 -> error_count=1, first_err_index=57, first_err_result=4000, pass=0.
- Flag mismatch only (exp flags 1, DUT 0): check_flags=0 -> pass=1; rerun with check_flags=1 -> error_count=1.
- LATENCY=3 with 3-stage registered DUT model, 20 vectors -> all checked, 0 errors; done asserted 4+ edges after last op_valid.
- stop_on_error=1, errors at indices 5 and 9 -> error_count=1, vector_count<=5+LATENCY+2, no vector >=9 issued.
- Reset asserted mid-RUN at vector 10 -> next cycle all outputs 0, IDLE; new start reruns from address 0 with clean counters.
